rot_amt_search: RTL and testbench

Sequential inverse of the parameterized barrel rotator. Given an original word `a` and a candidate result `y`, the block searches for the rotation amount that maps `a` to `y`. It reports that amount both as a right-rotate and as a left-rotate value, or reports that no such amount exists. It sits beside the rotator units as a checker/decoder: the rotator produces `y` from `(a, amt)`, and this block recovers `amt` from `(a, y)` with a start/done handshake.

---
 rtl/rot_amt_search.sv | 115 +++++++++++
 tb/tb_rot_amt_search.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rot_amt_search.sv
// Recovers the rotation amount that maps a to y, reported as right- and left-rotate values.
// Optional ROT_AMT_SEARCH_PARALLEL_EN: single-cycle search over all rotations with a priority encoder.
module rot_amt_search #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] y,
    output logic         ready,
    output logic         done,
    output logic         found,
    output logic [W-1:0] amt_right,
    output logic [W-1:0] amt_left
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] cand, tgt;
    logic         hit;
    logic         last;
    logic [W-1:0] hit_amt;

`ifdef ROT_AMT_SEARCH_PARALLEL_EN
    function automatic logic [N-1:0] rot_right(input logic [N-1:0] v, input int k);
        logic [2*N-1:0] d;
        d = {v, v} >> k;
        return d[N-1:0];
    endfunction

    // Descending scan so the lowest matching amount wins.
    always_comb begin
        hit     = 1'b0;
        hit_amt = '0;
        last    = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_right(cand, k) == tgt) begin
                hit     = 1'b1;
                hit_amt = W'(k);
            end
        end
    end
`else
    logic [W-1:0] cnt;

    assign hit     = (cand == tgt);
    assign hit_amt = cnt;
    assign last    = (cnt == W'(N - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEARCH;
            SEARCH:  if (hit || last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cand      <= '0;
            tgt       <= '0;
            found     <= 1'b0;
            amt_right <= '0;
            amt_left  <= '0;
`ifndef ROT_AMT_SEARCH_PARALLEL_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cand <= a;
                        tgt  <= y;
`ifndef ROT_AMT_SEARCH_PARALLEL_EN
                        cnt  <= '0;
`endif
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        found     <= 1'b1;
                        amt_right <= hit_amt;
                        amt_left  <= -hit_amt;
                    end else if (last) begin
                        found     <= 1'b0;
                        amt_right <= '0;
                        amt_left  <= '0;
                    end
`ifndef ROT_AMT_SEARCH_PARALLEL_EN
                    else begin
                        cand <= {cand[0], cand[N-1:1]};
                        cnt  <= cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_amt_search.sv
// Scoreboard bench for rot_amt_search: expected results queued at accept, checked on done.
module tb_rot_amt_search;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] y = '0;
    logic         ready, done, found;
    logic [W-1:0] amt_right, amt_left;

    rot_amt_search #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .y(y),
        .ready(ready), .done(done), .found(found),
        .amt_right(amt_right), .amt_left(amt_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         f;
        logic [W-1:0] r;
        logic [W-1:0] l;
        int           lat;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   ndone = 0;
    int   spurious = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            ndone++;
            if (exp_q.size() == 0) begin
                spurious++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("found", found, e.f);
                chk("amt_right", amt_right, e.r);
                chk("amt_left", amt_left, e.l);
                chk("latency", cyc - e.acc, e.lat);
                chk("ready_in_done", ready, 0);
            end
        end
    end

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int k);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[(i + k) % N];
        return r;
    endfunction

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int k);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[(i + k) % N] = v[i];
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 4 * N) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    // Drive one request, queue its expectation, optionally wait for its done.
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] yv,
                         input logic ef, input int er, input int el, input bit wait_done);
        exp_t e;
        int   d0;
        int   n;
        wait_ready();
        a = av;
        y = yv;
        start = 1'b1;
        e.f = ef;
        e.r = W'(er);
        e.l = W'(el);
`ifdef ROT_AMT_SEARCH_PARALLEL_EN
        e.lat = 1;
`else
        e.lat = ef ? er + 1 : N;
`endif
        e.acc = cyc + 1;
        exp_q.push_back(e);
        d0 = ndone;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        y = ~yv;
        if (wait_done) begin
            n = 0;
            while (ndone == d0 && n < 4 * N) begin
                @(negedge clk);
                n++;
            end
            if (ndone == d0) chk("done_timeout", 0, 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_amt_right", amt_right, 0);
        chk("rst_amt_left", amt_left, 0);

        issue(8'hD2, 8'h69, 1, 1, 7, 1);
        issue(8'hD2, 8'h5A, 1, 3, 5, 1);
        issue(8'hD2, 8'hD2, 1, 0, 0, 1);
        issue(8'hD2, 8'hFF, 0, 0, 0, 1);
        issue(8'hAA, 8'h55, 1, 1, 7, 1);
        issue(8'h00, 8'h00, 1, 0, 0, 1);

        // A second start during the search must be ignored.
        issue(8'hD2, 8'h5A, 1, 3, 5, 0);
        @(negedge clk);
        a = 8'hD2;
        y = 8'hD2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready();
        repeat (3) @(negedge clk);
        chk("ignored_start_queue", exp_q.size(), 0);
        chk("ignored_start_amt", amt_right, 3);

        // Reset mid-search: aborted request never produces done.
        issue(8'hD2, 8'h5A, 1, 3, 5, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_found", found, 0);
        chk("abort_amt_right", amt_right, 0);
        chk("abort_amt_left", amt_left, 0);
        repeat (2 * N) @(negedge clk);
        chk("abort_no_done", spurious, 0);

        for (int k = 0; k < N; k++) issue(8'hD2, rotr(8'hD2, k), 1, k, (N - k) % N, 1);
        for (int k = 0; k < N; k++) issue(8'hB1, rotl(8'hB1, k), 1, (N - k) % N, k, 1);

        // Back-to-back random pairs with scoreboard-model expectations.
        for (int t = 0; t < 12; t++) begin
            logic [N-1:0] av, yv;
            int           kk;
            kk = -1;
            av = N'($urandom);
            yv = (t % 3 == 0) ? N'($urandom) : rotr(av, $urandom_range(0, N - 1));
            for (int k = N - 1; k >= 0; k--) if (rotr(av, k) == yv) kk = k;
            if (kk < 0) issue(av, yv, 0, 0, 0, 1);
            else        issue(av, yv, 1, kk, (N - kk) % N, 1);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("spurious_done", spurious, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
